// File: rtl/lfu.sv
// Least-frequently-used residency tracker for four request buttons.
// Each accepted tick bumps a saturating use counter; hot items are cached, cold ones evicted.
module lfu #(
  parameter int CAPACITY      = 3,
  parameter int CW            = 8,
  parameter int INSERT_THRESH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic timedClock,
  input  logic b1,
  input  logic b2,
  input  logic b3,
  input  logic b4,
  output logic l1,
  output logic l2,
  output logic l3,
  output logic l4
);

  localparam int N = 4;
  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t THRESH = cnt_t'(INSERT_THRESH);

  logic         tc_q;
  logic         tick;
  logic [N-1:0] req;
  logic [N-1:0] res_q, res_d;
  cnt_t         cnt_q [N];
  cnt_t         cnt_d [N];

  logic         sel_valid;
  logic [1:0]   sel;
  cnt_t         sel_next;
  int           res_cnt;
  logic         victim_found;
  logic [1:0]   victim;
  cnt_t         victim_cnt;

  assign tick = timedClock & ~tc_q;
  assign req  = {b4, b3, b2, b1};

  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    res_d        = res_q;
    cnt_d        = cnt_q;
    sel_valid    = 1'b0;
    sel          = '0;
    res_cnt      = 0;
    victim_found = 1'b0;
    victim       = '0;
    victim_cnt   = '0;

    // Scan downward so the lowest-numbered pressed button wins.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        sel       = 2'(i);
        sel_valid = 1'b1;
      end
    end

    for (int i = 0; i < N; i++) begin
      if (res_q[i]) res_cnt++;
    end

    // Strict less-than keeps the lowest-numbered item on count ties.
    for (int i = 0; i < N; i++) begin
      if (res_q[i] && (!victim_found || cnt_q[i] < victim_cnt)) begin
        victim       = 2'(i);
        victim_cnt   = cnt_q[i];
        victim_found = 1'b1;
      end
    end

    sel_next = (cnt_q[sel] == '1) ? cnt_q[sel] : cnt_q[sel] + cnt_t'(1);

    if (tick && sel_valid) begin
      cnt_d[sel] = sel_next;
      if (!res_q[sel] && sel_next >= THRESH) begin
        if (res_cnt < CAPACITY) begin
          res_d[sel] = 1'b1;
        end else if (victim_found) begin
          res_d[victim] = 1'b0;
          cnt_d[victim] = '0;
          res_d[sel]    = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tc_q  <= 1'b0;
      res_q <= '0;
      // NOTE: the counter bank is only four registers, so it is cleared by reset like any other flop.
      for (int i = 0; i < N; i++) cnt_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      tc_q  <= timedClock;
      res_q <= res_d;
      cnt_q <= cnt_d;
    end
  end

  assign l1 = res_q[0];
  assign l2 = res_q[1];
  assign l3 = res_q[2];
  assign l4 = res_q[3];

endmodule

// File: tb/tb_lfu.sv
// Self-checking bench for lfu: directed tick sequences against a behavioural cache model.
module tb_lfu;

  localparam int CAP    = 3;
  localparam int CW     = 8;
  localparam int THRESH = 2;
  localparam int MAXC   = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  logic timedClock;
  logic b1, b2, b3, b4;
  logic l1, l2, l3, l4;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  int cnt_m [4];
  bit res_m [4];

  lfu #(.CAPACITY(CAP), .CW(CW), .INSERT_THRESH(THRESH)) dut (
    .clk(clk), .rst(rst), .timedClock(timedClock),
    .b1(b1), .b2(b2), .b3(b3), .b4(b4),
    .l1(l1), .l2(l2), .l3(l3), .l4(l4)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [3:0] lights();
    return {l1, l2, l3, l4};
  endfunction

  function automatic logic [3:0] model_lights();
    return {res_m[0], res_m[1], res_m[2], res_m[3]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_clear();
    for (int k = 0; k < 4; k++) begin
      cnt_m[k] = 0;
      res_m[k] = 1'b0;
    end
  endfunction

  // btn is written {b1,b2,b3,b4}, so item k is btn[3-k].
  function automatic void model_tick(input logic [3:0] btn);
    int sel = -1;
    int occ = 0;
    int victim = -1;
    for (int k = 0; k < 4; k++) if (btn[3-k] === 1'b1 && sel < 0) sel = k;
    if (sel < 0) return;
    if (cnt_m[sel] < MAXC) cnt_m[sel] = cnt_m[sel] + 1;
    if (res_m[sel] || cnt_m[sel] < THRESH) return;
    for (int k = 0; k < 4; k++) if (res_m[k]) occ++;
    if (occ < CAP) begin
      res_m[sel] = 1'b1;
    end else begin
      for (int k = 0; k < 4; k++)
        if (res_m[k] && (victim < 0 || cnt_m[k] < cnt_m[victim])) victim = k;
      res_m[victim] = 1'b0;
      cnt_m[victim] = 0;
      res_m[sel]    = 1'b1;
    end
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("lights_vs_model", 32'(lights()), 32'(model_lights()));
      check("occupancy_le_cap", 32'($countones(lights()) <= CAP), 32'd1);
    end
  end

  // Called #1 after a rising edge; returns #1 after a rising edge.
  task automatic do_tick(input logic [3:0] btn);
    {b1, b2, b3, b4} = btn;
    timedClock = 1'b1;
    @(posedge clk);
    #1 model_tick(btn);
    repeat (2) @(posedge clk);
    #1 timedClock = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic ticks(input logic [3:0] btn, input int n);
    for (int t = 0; t < n; t++) do_tick(btn);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_clear();
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    {b1, b2, b3, b4} = 4'b0000;
  endtask

  initial begin
    rst        = 1'b0;
    timedClock = 1'b0;
    {b1, b2, b3, b4} = 4'bxxxx;
    @(posedge clk);
    #1;

    // Reset with unknown buttons, then an empty tick.
    rst = 1'b1;
    model_clear();
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 check("after_reset", 32'(lights()), 32'b0000);
    do_tick(4'b0000);
    check("idle_tick", 32'(lights()), 32'b0000);

    // Fill sequence and LFU eviction.
    do_tick(4'b1000);
    check("b1_tick1", 32'(lights()), 32'b0000);
    do_tick(4'b1000);
    check("b1_tick2", 32'(lights()), 32'b1000);
    ticks(4'b1000, 4);
    check("b1_tick6", 32'(lights()), 32'b1000);
    check("model_cnt1_6", 32'(cnt_m[0]), 32'd6);
    do_tick(4'b0100);
    check("b2_tick1", 32'(lights()), 32'b1000);
    do_tick(4'b0100);
    check("b2_tick2", 32'(lights()), 32'b1100);
    ticks(4'b0100, 4);
    check("b2_tick6", 32'(lights()), 32'b1100);
    do_tick(4'b0010);
    check("b3_tick1", 32'(lights()), 32'b1100);
    ticks(4'b0010, 3);
    check("b3_tick4", 32'(lights()), 32'b1110);
    do_tick(4'b0001);
    check("b4_tick1", 32'(lights()), 32'b1110);
    do_tick(4'b0001);
    check("b4_evicts_3", 32'(lights()), 32'b1101);
    check("model_cnt3_cleared", 32'(cnt_m[2]), 32'd0);

    // Simultaneous presses: only b1 is accepted.
    do_reset();
    ticks(4'b1010, 2);
    check("prio_b1_b3", 32'(lights()), 32'b1000);
    check("model_cnt3_zero", 32'(cnt_m[2]), 32'd0);
    do_tick(4'b0010);
    check("b3_alone1", 32'(lights()), 32'b1000);
    do_tick(4'b0010);
    check("b3_alone2", 32'(lights()), 32'b1010);

    // Tie eviction picks the lowest-numbered item.
    do_reset();
    ticks(4'b1000, 2);
    ticks(4'b0100, 2);
    ticks(4'b0010, 2);
    check("tie_fill", 32'(lights()), 32'b1110);
    ticks(4'b0001, 2);
    check("tie_evict_1", 32'(lights()), 32'b0111);

    // Saturation: a wrapped counter (300 mod 256 = 44) would lose to items at 50.
    do_reset();
    ticks(4'b1000, 300);
    check("sat_lights", 32'(lights()), 32'b1000);
    check("model_cnt1_sat", 32'(cnt_m[0]), 32'd255);
    ticks(4'b0100, 50);
    ticks(4'b0010, 50);
    ticks(4'b0001, 2);
    check("sat_no_wrap_evict", 32'(lights()), 32'b1011);

    // Asynchronous reset between ticks.
    do_reset();
    ticks(4'b1000, 2);
    ticks(4'b0100, 2);
    ticks(4'b0010, 2);
    check("pre_rst_1110", 32'(lights()), 32'b1110);
    #2 rst = 1'b1;
    model_clear();
    #1 check("async_rst_clear", 32'(lights()), 32'b0000);
    @(posedge clk);
    #1 rst = 1'b0;
    do_tick(4'b1000);
    check("post_rst_b1", 32'(lights()), 32'b0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
